// File: rtl/count_4bit.sv
// Up/down counter with parallel load; clear > load > count priority, wraps modulo 2^WIDTH.
// Latency: one ck edge from sampled inputs to count; count is a pure register output.
// Backpressure: none; an action is applied on every edge and the counter never holds.
//
// Ports:
//   ck     - clock, all state changes on the rising edge
//   reset  - synchronous active-high clear, overrides every other input
//   updown - count direction, 1 = +1, 0 = -1
//   out    - parallel-load enable; loads data, ignores updown
//   data   - preset value, sampled only when out=1 and reset=0
//   count  - current counter value (registered)
module count_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             ck,
  input  logic             reset,
  input  logic             updown,
  input  logic             out,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Plain WIDTH-bit add/subtract; the dropped carry/borrow gives the modulo wrap.
  always_ff @(posedge ck) begin
    if (reset) begin
      count <= '0;
    end else if (out) begin
      count <= data;
    end else if (updown) begin
      count <= count + ONE;
    end else begin
      count <= count - ONE;
    end
  end

endmodule

// File: tb/tb_count_4bit.sv
// Directed bench for count_4bit: inputs change on the falling edge, count is
// checked on the falling edge that follows each rising edge.
module tb_count_4bit;

  logic       ck;
  logic       reset;
  logic       updown;
  logic       out;
  logic [3:0] data;
  logic [3:0] count;

  int n_checks = 0;
  int n_errors = 0;

  count_4bit #(.WIDTH(4)) dut (
    .ck     (ck),
    .reset  (reset),
    .updown (updown),
    .out    (out),
    .data   (data),
    .count  (count)
  );

  // Period 6, first rising edge at t=3.
  initial ck = 1'b0;
  always #3 ck = ~ck;

  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: count=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one set of inputs across one rising edge, then check the result.
  task automatic step(input string tag, input logic r, input logic o, input logic u,
                      input logic [3:0] d, input logic [3:0] exp);
    reset  = r;
    out    = o;
    updown = u;
    data   = d;
    @(posedge ck);
    @(negedge ck);
    check_val(tag, count, exp);
  endtask

  initial begin
    //           tag              rst  out  ud    data   exp
    step("reset_over_load",   1'b1, 1'b1, 1'b0, 4'd8,  4'd0);   // edge t=3
    step("load_8",            1'b0, 1'b1, 1'b0, 4'd8,  4'd8);   // t=9
    step("load_13",           1'b0, 1'b1, 1'b0, 4'd13, 4'd13);  // t=15
    step("load_15",           1'b0, 1'b1, 1'b0, 4'd15, 4'd15);  // t=21
    step("load_15_again",     1'b0, 1'b1, 1'b0, 4'd15, 4'd15);  // t=27
    step("down_14",           1'b0, 1'b0, 1'b0, 4'd3,  4'd14);  // t=33
    step("down_13",           1'b0, 1'b0, 1'b0, 4'd3,  4'd13);  // t=39
    step("reset_mid_count",   1'b1, 1'b0, 1'b0, 4'd3,  4'd0);   // t=45
    step("reset_hold_load",   1'b1, 1'b1, 1'b0, 4'd9,  4'd0);   // reset still beats load
    step("reset_hold_up",     1'b1, 1'b0, 1'b1, 4'd9,  4'd0);
    step("release_up_from_0", 1'b0, 1'b0, 1'b1, 4'd9,  4'd1);
    step("wrap_load_15",      1'b0, 1'b1, 1'b0, 4'd15, 4'd15);
    step("wrap_up_0",         1'b0, 1'b0, 1'b1, 4'd7,  4'd0);
    step("wrap_up_1",         1'b0, 1'b0, 1'b1, 4'd7,  4'd1);
    step("wrap_load_0",       1'b0, 1'b1, 1'b1, 4'd0,  4'd0);
    step("wrap_down_15",      1'b0, 1'b0, 1'b0, 4'd7,  4'd15);
    step("wrap_down_14",      1'b0, 1'b0, 1'b0, 4'd7,  4'd14);
    step("prio_load_5_dn",    1'b0, 1'b1, 1'b0, 4'd5,  4'd5);
    step("prio_load_5_up",    1'b0, 1'b1, 1'b1, 4'd5,  4'd5);
    step("prio_load_5_dn2",   1'b0, 1'b1, 1'b0, 4'd5,  4'd5);
    step("prio_load_5_up2",   1'b0, 1'b1, 1'b1, 4'd5,  4'd5);
    step("prio_release_up",   1'b0, 1'b0, 1'b1, 4'd12, 4'd6);

    // data must be ignored when out=0: change it between and across edges.
    reset  = 1'b0;
    out    = 1'b0;
    updown = 1'b1;
    data   = 4'd0;
    #1 data = 4'd11;
    @(posedge ck);
    #1 data = 4'd2;
    @(negedge ck);
    check_val("data_ignored_up", count, 4'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
